// File: rtl/alu_iter.sv
// rtl/alu_iter.sv - iterative ALU with single-cycle logic/arith ops and multi-cycle multiply/divide
//
// Ports:
//   clk       rising-edge clock
//   reset     synchronous active-high reset
//   start     request, sampled when not busy
//   op        operation code (latched with start)
//   a, b      operands (latched with start)
//   result    registered result, held until the next completion
//   zero, negative, carry, overflow   registered flags updated with result
//   dbz       divide-by-zero indication, updated with result
//   busy      high while a multiply/divide iterates
//   done      one-cycle pulse when result/flags update
module alu_iter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             negative,
    output logic             carry,
    output logic             overflow,
    output logic             dbz,
    output logic             busy,
    output logic             done
);

    localparam int SHW   = $clog2(WIDTH);
    localparam int CNT_W = $clog2(WIDTH);

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_AND  = 4'h2;
    localparam logic [3:0] OP_OR   = 4'h3;
    localparam logic [3:0] OP_XOR  = 4'h4;
    localparam logic [3:0] OP_NOT  = 4'h5;
    localparam logic [3:0] OP_SLL  = 4'h6;
    localparam logic [3:0] OP_SRL  = 4'h7;
    localparam logic [3:0] OP_SRA  = 4'h8;
    localparam logic [3:0] OP_SLT  = 4'h9;
    localparam logic [3:0] OP_MUL  = 4'hA;
    localparam logic [3:0] OP_MULH = 4'hB;
    localparam logic [3:0] OP_DIV  = 4'hC;
    localparam logic [3:0] OP_REM  = 4'hD;
    localparam logic [3:0] OP_PASA = 4'hE;
    localparam logic [3:0] OP_PASB = 4'hF;

    typedef enum logic [1:0] {S_IDLE, S_ITER, S_DONE} state_t;

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [3:0]             op_q, op_d;
    logic [WIDTH-1:0]       a_q, a_d;
    logic [WIDTH-1:0]       b_q, b_d;
    // Multiply: {partial high, remaining multiplier}. Divide: low half holds
    // the dividend bits being shifted out and the quotient bits shifted in.
    logic [2*WIDTH-1:0]     acc_q, acc_d;
    logic [WIDTH:0]         rem_q, rem_d;
    logic [WIDTH-1:0]       result_q, result_d;
    logic                   zero_q, zero_d;
    logic                   negative_q, negative_d;
    logic                   carry_q, carry_d;
    logic                   overflow_q, overflow_d;
    logic                   dbz_q, dbz_d;

    // Single-cycle datapath
    logic [WIDTH:0]         sum_ext, dif_ext;
    logic [SHW-1:0]         sh;
    logic [WIDTH-1:0]       sc_res;
    logic                   sc_c, sc_v;
    logic                   start_multi;

    always_comb begin
        sum_ext = {1'b0, a} + {1'b0, b};
        dif_ext = {1'b0, a} - {1'b0, b};
        sh      = b[SHW-1:0];
        sc_res  = '0;
        sc_c    = 1'b0;
        sc_v    = 1'b0;
        case (op)
            OP_ADD: begin
                sc_res = sum_ext[WIDTH-1:0];
                sc_c   = sum_ext[WIDTH];
                sc_v   = (a[WIDTH-1] == b[WIDTH-1]) && (sum_ext[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                sc_res = dif_ext[WIDTH-1:0];
                // Borrow out of the extended subtract; carry means no borrow.
                sc_c   = ~dif_ext[WIDTH];
                sc_v   = (a[WIDTH-1] != b[WIDTH-1]) && (dif_ext[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND:  sc_res = a & b;
            OP_OR:   sc_res = a | b;
            OP_XOR:  sc_res = a ^ b;
            OP_NOT:  sc_res = ~a;
            OP_SLL:  sc_res = a << sh;
            OP_SRL:  sc_res = a >> sh;
            OP_SRA:  sc_res = $signed(a) >>> sh;
            OP_SLT:  sc_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_PASA: sc_res = a;
            OP_PASB: sc_res = b;
            default: sc_res = '0;
        endcase
        start_multi = (op == OP_MUL) || (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    end

    // One iteration step
    logic [WIDTH:0]         mul_sum;
    logic [2*WIDTH-1:0]     mul_next;
    logic [WIDTH+1:0]       div_shift, div_diff;
    logic [WIDTH:0]         div_rem_next;
    logic [WIDTH-1:0]       div_quo_next;
    logic                   iter_mul;

    always_comb begin
        iter_mul = (op_q == OP_MUL) || (op_q == OP_MULH);
        mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, a_q} : '0);
        mul_next = {mul_sum, acc_q[WIDTH-1:1]};
        // Restoring step: trial-subtract the divisor from the shifted
        // remainder; a negative trial keeps the shifted value.
        div_shift = {rem_q, acc_q[WIDTH-1]};
        div_diff  = div_shift - {2'b00, b_q};
        if (div_diff[WIDTH+1]) begin
            div_rem_next = div_shift[WIDTH:0];
        end else begin
            div_rem_next = div_diff[WIDTH:0];
        end
        div_quo_next = {acc_q[WIDTH-2:0], ~div_diff[WIDTH+1]};
    end

    // Next-state and register-input logic
    logic                   load;
    logic [WIDTH-1:0]       new_res;
    logic                   new_c, new_v, new_dbz;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        op_d       = op_q;
        a_d        = a_q;
        b_d        = b_q;
        acc_d      = acc_q;
        rem_d      = rem_q;
        result_d   = result_q;
        zero_d     = zero_q;
        negative_d = negative_q;
        carry_d    = carry_q;
        overflow_d = overflow_q;
        dbz_d      = dbz_q;
        load       = 1'b0;
        new_res    = '0;
        new_c      = 1'b0;
        new_v      = 1'b0;
        new_dbz    = 1'b0;

        case (state_q)
            S_ITER: begin
                if (iter_mul) begin
                    acc_d = mul_next;
                end else begin
                    acc_d = {acc_q[2*WIDTH-1:WIDTH], div_quo_next};
                    rem_d = div_rem_next;
                end
                if (cnt_q == CNT_W'(WIDTH-1)) begin
                    load    = 1'b1;
                    state_d = S_DONE;
                    if (iter_mul) begin
                        new_res = (op_q == OP_MUL) ? mul_next[WIDTH-1:0] : mul_next[2*WIDTH-1:WIDTH];
                        new_c   = |mul_next[2*WIDTH-1:WIDTH];
                    end else begin
                        new_res = (op_q == OP_DIV) ? div_quo_next : div_rem_next[WIDTH-1:0];
                        new_dbz = (b_q == '0);
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                // IDLE and DONE accept a request identically.
                state_d = S_IDLE;
                if (start) begin
                    if (start_multi) begin
                        state_d = S_ITER;
                        cnt_d   = '0;
                        op_d    = op;
                        a_d     = a;
                        b_d     = b;
                        rem_d   = '0;
                        if ((op == OP_MUL) || (op == OP_MULH)) begin
                            acc_d = {{WIDTH{1'b0}}, b};
                        end else begin
                            acc_d = {{WIDTH{1'b0}}, a};
                        end
                    end else begin
                        state_d = S_DONE;
                        load    = 1'b1;
                        new_res = sc_res;
                        new_c   = sc_c;
                        new_v   = sc_v;
                    end
                end
            end
        endcase

        if (load) begin
            result_d   = new_res;
            zero_d     = (new_res == '0);
            negative_d = new_res[WIDTH-1];
            carry_d    = new_c;
            overflow_d = new_v;
            dbz_d      = new_dbz;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            op_q       <= '0;
            a_q        <= '0;
            b_q        <= '0;
            acc_q      <= '0;
            rem_q      <= '0;
            result_q   <= '0;
            zero_q     <= 1'b0;
            negative_q <= 1'b0;
            carry_q    <= 1'b0;
            overflow_q <= 1'b0;
            dbz_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            op_q       <= op_d;
            a_q        <= a_d;
            b_q        <= b_d;
            acc_q      <= acc_d;
            rem_q      <= rem_d;
            result_q   <= result_d;
            zero_q     <= zero_d;
            negative_q <= negative_d;
            carry_q    <= carry_d;
            overflow_q <= overflow_d;
            dbz_q      <= dbz_d;
        end
    end

    // Output logic
    always_comb begin
        busy     = (state_q == S_ITER);
        done     = (state_q == S_DONE);
        result   = result_q;
        zero     = zero_q;
        negative = negative_q;
        carry    = carry_q;
        overflow = overflow_q;
        dbz      = dbz_q;
    end

endmodule

// File: tb/tb_alu_iter.sv
// tb/tb_alu_iter.sv - self-checking bench for alu_iter against an arithmetic reference model
module tb_alu_iter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [3:0]  op = 4'h0;
    logic [15:0] a = 16'h0;
    logic [15:0] b = 16'h0;
    logic [15:0] result;
    logic        zero, negative, carry, overflow, dbz, busy, done;

    int checks = 0;
    int errors = 0;

    alu_iter #(.WIDTH(16)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .op       (op),
        .a        (a),
        .b        (b),
        .result   (result),
        .zero     (zero),
        .negative (negative),
        .carry    (carry),
        .overflow (overflow),
        .dbz      (dbz),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    // Packed view: {result, zero, negative, carry, overflow, dbz}
    function automatic logic [20:0] model(input logic [3:0] mop, input logic [15:0] ma, input logic [15:0] mb);
        logic [15:0] r;
        logic        c, v, d;
        logic [16:0] s17;
        logic [31:0] p;
        int unsigned sa;
        r = 16'h0; c = 1'b0; v = 1'b0; d = 1'b0;
        sa = int'(mb[3:0]);
        p  = 32'(ma) * 32'(mb);
        case (mop)
            4'h0: begin
                s17 = 17'(ma) + 17'(mb);
                r = s17[15:0]; c = s17[16];
                v = ($signed(ma) + $signed(mb) > 32767) || ($signed(ma) + $signed(mb) < -32768);
            end
            4'h1: begin
                r = ma - mb; c = (ma >= mb);
                v = (int'($signed(ma)) - int'($signed(mb)) > 32767) || (int'($signed(ma)) - int'($signed(mb)) < -32768);
            end
            4'h2: r = ma & mb;
            4'h3: r = ma | mb;
            4'h4: r = ma ^ mb;
            4'h5: r = ~ma;
            4'h6: r = ma << sa;
            4'h7: r = ma >> sa;
            4'h8: r = 16'(int'($signed(ma)) >>> sa);
            4'h9: r = (int'($signed(ma)) < int'($signed(mb))) ? 16'd1 : 16'd0;
            4'hA: begin r = p[15:0];  c = (p[31:16] != 16'h0); end
            4'hB: begin r = p[31:16]; c = (p[31:16] != 16'h0); end
            4'hC: begin r = (mb == 0) ? 16'hFFFF : ma / mb; d = (mb == 0); end
            4'hD: begin r = (mb == 0) ? ma : ma % mb;       d = (mb == 0); end
            4'hE: r = ma;
            default: r = mb;
        endcase
        return {r, (r == 16'h0), r[15], c, v, d};
    endfunction

    function automatic bit is_multi(input logic [3:0] mop);
        return (mop >= 4'hA) && (mop <= 4'hD);
    endfunction

    // Issue one op and wait (bounded) for done; returns observed outputs,
    // latency in cycles (-1 if no done), busy-cycle count and busy&done overlaps.
    task automatic run_op(input logic [3:0] o, input logic [15:0] x, input logic [15:0] y,
                          output logic [20:0] obs, output int lat, output int nbusy, output int overlap);
        @(negedge clk);
        start = 1'b1; op = o; a = x; b = y;
        @(posedge clk);
        #1 start = 1'b0;
        lat = -1; nbusy = 0; overlap = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (busy) nbusy++;
            if (busy && done) overlap++;
            if (done) begin
                lat = i;
                break;
            end
        end
        obs = {result, zero, negative, carry, overflow, dbz};
    endtask

    task automatic test_reset;
        reset = 1'b1; start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({result, zero, negative, carry, overflow, dbz, busy, done} !== 23'h0) begin
            errors++;
            $display("FAIL reset_state got=%h want=0", {result, zero, negative, carry, overflow, dbz, busy, done});
        end
        reset = 1'b0;
    endtask

    task automatic test_directed;
        logic [3:0]  top [9] = '{4'h0, 4'h1, 4'h8, 4'hA, 4'hB, 4'hC, 4'hD, 4'hC, 4'hD};
        logic [15:0] ta  [9] = '{16'h7FFF, 16'h0003, 16'h8000, 16'h0123, 16'h0123, 16'd1000, 16'd1000, 16'h1234, 16'h1234};
        logic [15:0] tb  [9] = '{16'h0001, 16'h0005, 16'h0003, 16'h0456, 16'h0456, 16'd7, 16'd7, 16'h0000, 16'h0000};
        logic [20:0] texp[9] = '{{16'h8000, 5'b01010}, {16'hFFFE, 5'b01000}, {16'hF000, 5'b01000},
                                 {16'hEDC2, 5'b01100}, {16'h0004, 5'b00100}, {16'h008E, 5'b00000},
                                 {16'h0006, 5'b00000}, {16'hFFFF, 5'b01001}, {16'h1234, 5'b00001}};
        logic [20:0] obs;
        int lat, nb, ov, want_lat;
        for (int i = 0; i < 9; i++) begin
            run_op(top[i], ta[i], tb[i], obs, lat, nb, ov);
            want_lat = is_multi(top[i]) ? 17 : 1;
            checks++;
            if (obs !== texp[i]) begin
                errors++;
                $display("FAIL directed_%0d op=%h got=%h want=%h", i, top[i], obs, texp[i]);
            end
            checks++;
            if (lat !== want_lat || nb !== want_lat - 1 || ov !== 0) begin
                errors++;
                $display("FAIL directed_timing_%0d lat=%0d busy=%0d overlap=%0d want lat=%0d busy=%0d", i, lat, nb, ov, want_lat, want_lat - 1);
            end
            @(negedge clk);
            checks++;
            if (done !== 1'b0 || result !== texp[i][20:5]) begin
                errors++;
                $display("FAIL directed_hold_%0d done=%b result=%h want done=0 result=%h", i, done, result, texp[i][20:5]);
            end
        end
    endtask

    task automatic test_random;
        logic [3:0]  o;
        logic [15:0] x, y;
        logic [20:0] obs, exp_v;
        int lat, nb, ov, want_lat;
        for (int i = 0; i < 60; i++) begin
            o = 4'($urandom_range(0, 15));
            x = 16'($urandom);
            y = 16'($urandom);
            if (($urandom_range(0, 4) == 0)) y = 16'h0;
            exp_v = model(o, x, y);
            run_op(o, x, y, obs, lat, nb, ov);
            want_lat = is_multi(o) ? 17 : 1;
            checks++;
            if (obs !== exp_v || lat !== want_lat || nb !== want_lat - 1 || ov !== 0) begin
                errors++;
                $display("FAIL random_%0d op=%h a=%h b=%h got=%h lat=%0d busy=%0d want=%h lat=%0d", i, o, x, y, obs, lat, nb, exp_v, want_lat);
            end
        end
    endtask

    task automatic test_ignore_start;
        int lat;
        lat = -1;
        @(negedge clk);
        start = 1'b1; op = 4'hC; a = 16'd1000; b = 16'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        start = 1'b1; op = 4'h0; a = 16'h0001; b = 16'h0001;
        @(negedge clk);
        start = 1'b0;
        // 6 negedges have passed since the DIV was accepted.
        for (int i = 7; i <= 40; i++) begin
            @(negedge clk);
            if (done) begin
                lat = i;
                break;
            end
        end
        checks++;
        if (lat !== 17 || result !== 16'h008E || dbz !== 1'b0) begin
            errors++;
            $display("FAIL ignore_start lat=%0d result=%h dbz=%b want lat=17 result=008e dbz=0", lat, result, dbz);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || result !== 16'h008E) begin
            errors++;
            $display("FAIL ignore_start_no_queue done=%b result=%h want done=0 result=008e", done, result);
        end
    endtask

    task automatic test_back_to_back;
        @(negedge clk);
        start = 1'b1; op = 4'hE; b = 16'h0;
        for (int i = 1; i <= 4; i++) begin
            if (i > 1) begin
                checks++;
                if (done !== 1'b1 || result !== 16'(i - 1)) begin
                    errors++;
                    $display("FAIL back_to_back_%0d done=%b result=%h want done=1 result=%h", i - 1, done, result, 16'(i - 1));
                end
            end
            if (i <= 3) a = 16'(i);
            else start = 1'b0;
            @(negedge clk);
        end
        checks++;
        if (done !== 1'b0 || result !== 16'd3) begin
            errors++;
            $display("FAIL back_to_back_end done=%b result=%h want done=0 result=0003", done, result);
        end
    endtask

    task automatic test_reset_mid;
        logic [20:0] obs;
        int lat, nb, ov, stray;
        @(negedge clk);
        start = 1'b1; op = 4'hA; a = 16'h0123; b = 16'h0456;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (8) @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_busy busy=%b want 1", busy);
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checks++;
        if ({result, zero, negative, carry, overflow, dbz, busy, done} !== 23'h0) begin
            errors++;
            $display("FAIL reset_mid_state got=%h want=0", {result, zero, negative, carry, overflow, dbz, busy, done});
        end
        stray = 0;
        repeat (20) begin
            @(negedge clk);
            if (done || busy) stray++;
        end
        checks++;
        if (stray !== 0) begin
            errors++;
            $display("FAIL reset_mid_discard active_cycles=%0d want 0", stray);
        end
        run_op(4'h0, 16'h0002, 16'h0003, obs, lat, nb, ov);
        checks++;
        if (obs !== {16'h0005, 5'b00000} || lat !== 1) begin
            errors++;
            $display("FAIL reset_mid_add got=%h lat=%0d want=%h lat=1", obs, lat, {16'h0005, 5'b00000});
        end
    endtask

    initial begin
        test_reset;
        test_directed;
        test_random;
        test_ignore_start;
        test_back_to_back;
        test_reset_mid;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
